// File: rtl/hs4_sync_bridge.sv
// Receiver for a bundled-data 4-phase handshake: synchronises req_i into clk_i,
// captures data_i into a circular FIFO and presents the FIFO as a valid/ready stream.
module hs4_sync_bridge #(
    parameter int DataWidth  = 32,
    parameter int Depth      = 2,
    parameter int SyncStages = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    input  logic [DataWidth-1:0]         data_i,
    output logic                         ack_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [DataWidth-1:0]         data_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int CountW = $clog2(Depth + 1);
    localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CountW-1:0] DepthC  = CountW'(Depth);
    localparam logic [PtrW-1:0]   LastPtr = PtrW'(Depth - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_e;

    state_e                 state_q;
    logic                   ack_q;
    logic [SyncStages-1:0]  sync_q;
    logic                   req_s;
    logic [DataWidth-1:0]   mem_q [Depth];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]      count_q, count_d;
    logic                   push;
    logic                   pop;

    // req_i is asynchronous; only the last flop of this chain is ever observed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], req_i};
        end
    end

    assign req_s = sync_q[SyncStages-1];

    // Full test uses the pre-edge count, so a same-cycle pop never frees a slot for push.
    assign push = (state_q == IDLE) && req_s && (count_q < DepthC);
    assign pop  = (count_q != '0) && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q <= ACKED;
                        ack_q   <= 1'b1;
                    end
                end
                ACKED: begin
                    if (!req_s) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign ack_o   = ack_q;
    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: tb/tb_hs4_sync_bridge.sv
// Bench for hs4_sync_bridge: cycle vectors and hand sequences on a Depth=2 instance,
// randomized 4-phase traffic against a queue model on a Depth=3 instance.
module tb_hs4_sync_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req2, ack2, valid2, ready2;
    logic [31:0] din2, dout2;
    logic [1:0]  cnt2;
    logic        req3, ack3, valid3, ready3;
    logic [31:0] din3, dout3;
    logic [1:0]  cnt3;

    hs4_sync_bridge #(.DataWidth(32), .Depth(2), .SyncStages(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req2), .data_i(din2), .ack_o(ack2),
        .valid_o(valid2), .ready_i(ready2), .data_o(dout2), .count_o(cnt2)
    );

    hs4_sync_bridge #(.DataWidth(32), .Depth(3), .SyncStages(2)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .data_i(din3), .ack_o(ack3),
        .valid_o(valid3), .ready_i(ready3), .data_o(dout3), .count_o(cnt3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check2(input string tag, input logic ack, input logic valid,
                          input logic [1:0] cnt, input logic [31:0] dout);
        check({tag, "_ack"}, ack2, ack);
        check({tag, "_valid"}, valid2, valid);
        check({tag, "_count"}, cnt2, cnt);
        check({tag, "_data"}, dout2, dout);
    endtask

    typedef struct {
        logic        req;
        logic        rdy;
        logic [31:0] din;
        int          n;
        logic        ack;
        logic        valid;
        logic [1:0]  cnt;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic req, logic rdy, logic [31:0] din, int n,
                                logic ack, logic valid, logic [1:0] cnt, logic [31:0] dout);
        vec_t v;
        v.req = req; v.rdy = rdy; v.din = din; v.n = n;
        v.ack = ack; v.valid = valid; v.cnt = cnt; v.dout = dout;
        return v;
    endfunction

    logic [31:0] exp_q[$];

    initial begin
        int          drv_st, gap, words, wait_cyc, lat;
        logic        prev_fire, prev_ack, abort;
        logic [31:0] cur;
        int          max_words;

        rst = 1'b1;
        req2 = 1'b0; ready2 = 1'b0; din2 = '0;
        req3 = 1'b0; ready3 = 1'b0; din3 = '0;
        repeat (2) tick();
        check2("reset", 1'b0, 1'b0, 2'd0, 32'h0);
        check("reset3_ack", ack3, 1'b0);
        check("reset3_valid", valid3, 1'b0);
        check("reset3_count", cnt3, 2'd0);
        check("reset3_data", dout3, 32'h0);
        rst = 1'b0;

        // Single transfer, then Depth=2 backpressure with words 1, 2, 3.
        tbl.push_back(mk(1, 1, 32'hDEADBEEF, 2, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'hDEADBEEF, 1, 1, 1, 1, 32'hDEADBEEF));
        tbl.push_back(mk(1, 1, 32'hDEADBEEF, 1, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'hDEADBEEF, 2, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'hDEADBEEF, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h1, 2, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h1, 1, 1, 1, 1, 32'h1));
        tbl.push_back(mk(0, 0, 32'h1, 3, 0, 1, 1, 32'h1));
        tbl.push_back(mk(1, 0, 32'h2, 3, 1, 1, 2, 32'h1));
        tbl.push_back(mk(0, 0, 32'h2, 3, 0, 1, 2, 32'h1));
        tbl.push_back(mk(1, 0, 32'h3, 10, 0, 1, 2, 32'h1));
        tbl.push_back(mk(1, 1, 32'h3, 1, 0, 1, 1, 32'h2));
        tbl.push_back(mk(1, 0, 32'h3, 1, 1, 1, 2, 32'h2));
        tbl.push_back(mk(0, 1, 32'h3, 1, 1, 1, 1, 32'h3));
        tbl.push_back(mk(0, 1, 32'h3, 1, 1, 0, 0, 32'h2));
        tbl.push_back(mk(0, 0, 32'h3, 1, 0, 0, 0, 32'h2));

        for (int i = 0; i < tbl.size(); i++) begin
            req2 = tbl[i].req;
            ready2 = tbl[i].rdy;
            din2 = tbl[i].din;
            repeat (tbl[i].n) tick();
            check2($sformatf("vec%0d", i), tbl[i].ack, tbl[i].valid, tbl[i].cnt, tbl[i].dout);
        end

        // Request held high long after ack: exactly one push, ack held.
        req2 = 1'b1; din2 = 32'h55; ready2 = 1'b0;
        repeat (3) tick();
        check2("hold_start", 1'b1, 1'b1, 2'd1, 32'h55);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("hold%0d_ack", i), ack2, 1'b1);
            check($sformatf("hold%0d_count", i), cnt2, 2'd1);
        end
        req2 = 1'b0;
        repeat (2) tick();
        check("hold_fall2_ack", ack2, 1'b1);
        tick();
        check("hold_fall3_ack", ack2, 1'b0);

        // Push and pop on the same edge at count=1.
        req2 = 1'b1; din2 = 32'h66;
        repeat (2) tick();
        ready2 = 1'b1;
        tick();
        check2("pushpop", 1'b1, 1'b1, 2'd1, 32'h66);
        ready2 = 1'b0; req2 = 1'b0;
        repeat (3) tick();
        check2("pushpop_rtz", 1'b0, 1'b1, 2'd1, 32'h66);
        ready2 = 1'b1;
        tick();
        check("pushpop_drain_count", cnt2, 2'd0);
        ready2 = 1'b0;

        // Reset while ACKED with one entry stored.
        req2 = 1'b1; din2 = 32'hA5;
        repeat (3) tick();
        check2("pre_rst", 1'b1, 1'b1, 2'd1, 32'hA5);
        rst = 1'b1;
        tick();
        check2("mid_rst", 1'b0, 1'b0, 2'd0, 32'h0);
        rst = 1'b0;
        repeat (2) tick();
        check("post_rst2_ack", ack2, 1'b0);
        tick();
        check2("post_rst3", 1'b1, 1'b1, 2'd1, 32'hA5);
        req2 = 1'b0;
        repeat (3) tick();
        check("post_rst_rtz_ack", ack2, 1'b0);
        ready2 = 1'b1;
        tick();
        check("post_rst_drain_count", cnt2, 2'd0);
        ready2 = 1'b0;

        // Randomized traffic on the Depth=3 instance; words 0..9 first with ready held high.
        max_words = 70;
        drv_st = 0; gap = 0; words = 0; wait_cyc = 0; lat = 0;
        prev_fire = 1'b0; prev_ack = 1'b0; abort = 1'b0; cur = '0;
        ready3 = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (words == max_words && drv_st == 0 && exp_q.size() == 0) break;
            tick();
            if (drv_st == 1) lat++;
            if (prev_fire) void'(exp_q.pop_front());
            if (ack3 && !prev_ack) begin
                check("rnd_ack_latency", 32'(lat >= 3), 32'd1);
                check("rnd_ack_not_full", 32'(exp_q.size() < 3), 32'd1);
                exp_q.push_back(cur);
            end
            check("rnd_count", cnt3, 32'(exp_q.size()));
            check("rnd_valid", valid3, 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("rnd_data", dout3, exp_q[0]);

            case (drv_st)
                0: begin
                    if (words < max_words) begin
                        if (gap == 0) begin
                            cur = (words < 10) ? 32'(words) : $urandom;
                            din3 = cur;
                            req3 = 1'b1;
                            lat = 0;
                            wait_cyc = 0;
                            drv_st = 1;
                            words++;
                        end else begin
                            gap--;
                        end
                    end
                end
                1: begin
                    if (ack3) begin
                        req3 = 1'b0;
                        wait_cyc = 0;
                        drv_st = 2;
                    end
                end
                default: begin
                    if (!ack3) begin
                        gap = $urandom_range(0, 3);
                        drv_st = 0;
                    end
                end
            endcase
            if (drv_st != 0) begin
                wait_cyc++;
                if (wait_cyc > 300) begin
                    check("rnd_handshake_timeout", 32'(wait_cyc), 32'd300);
                    abort = 1'b1;
                end
            end
            if (abort) break;
            ready3 = (words <= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            prev_fire = valid3 && ready3;
            prev_ack = ack3;
        end
        check("rnd_words_sent", 32'(words), 32'(max_words));
        check("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hs4_sync_bridge.md
# hs4_sync_bridge

Receiver stage directly downstream of the three-way request join in the asynchronous datapath. It accepts the join's bundled-data 4-phase handshake (`req_i`/`ack_o` plus data), synchronises the request into the `clk_i` domain, captures the data into a small FIFO, and presents it to the clocked pipeline as a valid/ready stream. It is the only point where join output enters synchronous logic.

## Interface
- `DataWidth`, default 32: width of the bundled data word.
- `Depth`, default 2: number of FIFO entries; must be ≥1.
- `SyncStages`, default 2: number of flops in the `req_i` synchroniser; must be ≥2.

- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  4-phase request from the join output (asynchronous to `clk_i`).
- `data_i`  in  DataWidth  bundled data; stable from before `req_i` rises until after `ack_o` rises.
- `ack_o`  out  1  4-phase acknowledge back to the join; registered.
- `valid_o`  out  1  FIFO head valid.
- `ready_i`  in  1  downstream accepts head.
- `data_o`  out  DataWidth  FIFO head word.
- `count_o`  out  $clog2(Depth+1)  FIFO occupancy.

## Operation
- Synchroniser: `req_i` passes through a `SyncStages`-deep flop chain; its last stage is `req_s`. No other logic samples `req_i`.
- Handshake FSM, two states:
  - IDLE (`ack_o`=0): if `req_s`=1 and count<Depth, write `data_i` at the write pointer, increment the write pointer, set `ack_o`=1, go to ACKED. If `req_s`=1 and FIFO full, stay in IDLE with `ack_o`=0 (backpressure), no write.
  - ACKED (`ack_o`=1): when `req_s`=0, set `ack_o`=0 and go to IDLE. No write in this state.
- Capture of `data_i` is legal because the bundled-data constraint keeps it stable until `ack_o` rises.
- FIFO: circular buffer of Depth entries. Read/write pointers wrap from Depth-1 to 0; Depth need not be a power of two.
  - Push occurs on the IDLE→ACKED transition.
  - Pop occurs on `valid_o` && `ready_i`.
  - `count` next value = count + push − pop.
  - Full test uses the pre-edge count: a pop in the same cycle does not enable a push.
  - Push and pop in the same cycle are allowed when 0<count<Depth.
- `valid_o` = (count≠0). `data_o` = entry at the read pointer, combinational from storage. `count_o` = count.
- `ready_i` while `valid_o`=0 has no effect.

## Timing
- Reset values: `ack_o`=0, `valid_o`=0, `count_o`=0, `data_o`=0 (storage cleared), both pointers 0, all synchroniser flops 0, FSM state IDLE.
- Forward latency (FIFO not full): call the first rising edge that samples `req_i`=1 edge 0. Then `req_s`=1 after edge SyncStages−1, and `ack_o`, `valid_o` and the count increment all appear after edge SyncStages. Default: 3 edges from `req_i` rise to `ack_o` rise.
- Return-to-zero: `ack_o` falls after edge SyncStages, counted from the first edge that samples `req_i`=0.
- Minimum full 4-phase cycle is 2·(SyncStages+1) clocks plus the upstream delays.
- Pop: the read pointer and count update on the same edge; the next word appears on `data_o` immediately after that edge.
- Full with a pending request: `ack_o` rises on the first edge where the pre-edge count<Depth and `req_s`=1. When Depth=1 and a pop occurs at edge n, that is edge n+1.
- Reset mid-handshake: every register returns to its reset value on the edge where `rst_i`=1, including `ack_o`→0 and any FIFO contents (discarded). The join must be reset concurrently. After `rst_i` deasserts, a request still high is treated as a new request.

## Test plan
- Single transfer, `ready_i`=1, `data_i`=0xDEADBEEF, `req_i` rises → `ack_o`=1 and `valid_o`=1 with `data_o`=0xDEADBEEF exactly 3 edges later. Pop on the next edge gives count 0. Drop `req_i` → `ack_o`=0 three edges later.
- Backpressure with `ready_i`=0 and Depth=2: send 0x1, 0x2, 0x3 → the first two are acked and count_o=2. The third holds `ack_o`=0 indefinitely. Raise `ready_i` for one cycle → 0x1 pops, then `ack_o` rises for 0x3 one edge later. The final drain order is 0x2, 0x3.
- Wrap-around with Depth=3 and `ready_i`=1: stream 10 words 0..9 → output order 0..9, no loss or duplication, and count_o never exceeds 3.
- Simultaneous push and pop at count=1 → count stays 1 and the head advances to the next word in order.
- Reset mid-handshake: assert `rst_i` while in ACKED with count=1 → on the next edge `ack_o`=0, `valid_o`=0, count_o=0, and data_o=0.
- Protocol check: hold `req_i` high for 20 cycles after ack with the FIFO non-full → exactly one push occurs and `ack_o` stays 1 until `req_i` falls.
